// File: rtl/seq_lookahead_addsub_pkg.sv
// Shared definitions for the sequential lookahead adder/subtractor.
//   - SLICE_W : width of the datapath slice processed per cycle
//   - state_e : FSM state encoding
package seq_lookahead_addsub_pkg;

  localparam int unsigned SLICE_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_lookahead_addsub_cla8_slice.sv
// 8-bit carry-lookahead adder slice, purely combinational.
// Ports:
//   x, y : 8-bit addends
//   cin  : carry in
//   sum  : 8-bit sum
//   cout : carry out of bit 7
module cla8_slice
  import seq_lookahead_addsub_pkg::*;
(
  input  logic [SLICE_W-1:0] x,
  input  logic [SLICE_W-1:0] y,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W-1:0] w_g;
  logic [SLICE_W-1:0] w_p;
  logic [SLICE_W:0]   w_c;

  assign w_g = x & y;
  assign w_p = x ^ y;

  // Each carry is built as its fully expanded sum of products:
  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, so no carry depends on another.
  always_comb begin
    logic v_term;
    logic v_pprod;
    w_c    = '0;
    w_c[0] = cin;
    for (int i = 0; i < SLICE_W; i++) begin
      v_term  = 1'b0;
      v_pprod = 1'b1;
      for (int j = i; j >= 0; j--) begin
        v_term  = v_term | (w_g[j] & v_pprod);
        v_pprod = v_pprod & w_p[j];
      end
      w_c[i+1] = v_term | (v_pprod & cin);
    end
  end

  assign sum  = w_p ^ w_c[SLICE_W-1:0];
  assign cout = w_c[SLICE_W];

endmodule

// File: rtl/seq_lookahead_addsub.sv
// Multi-cycle WIDTH-bit adder/subtractor. One 8-bit lookahead slice is
// evaluated per cycle, least-significant first, with the inter-slice carry
// held in a register. Subtraction is A + ~B + 1.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : operand handshake (op_sub, a, b sampled on accept)
//   out_valid/out_ready : result handshake
//   result              : sum/difference modulo 2^WIDTH
//   carry_out, borrow   : raw MSB carry, and op_sub & ~carry_out
//   overflow, zero      : signed overflow, result == 0
// WIDTH must be a multiple of 8 and at least 8.
module seq_lookahead_addsub
  import seq_lookahead_addsub_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             borrow,
  output logic             overflow,
  output logic             zero
);

  localparam int unsigned SLICES = WIDTH / SLICE_W;
  localparam int unsigned CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SLICES - 1);

  state_e             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_res;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_op_sub;
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry_out;
  logic               r_borrow;
  logic               r_overflow;
  logic               r_zero;

  logic [SLICE_W-1:0] w_sum;
  logic               w_cout;
  logic [WIDTH-1:0]   w_res_next;
  logic [WIDTH-1:0]   w_b_eff;

  cla8_slice u_slice (
    .x    (r_a[SLICE_W-1:0]),
    .y    (r_b[SLICE_W-1:0]),
    .cin  (r_carry),
    .sum  (w_sum),
    .cout (w_cout)
  );

  // New slice enters at the top; after SLICES shifts the sum is in place.
  if (SLICES == 1) begin : g_one_slice
    assign w_res_next = w_sum;
  end else begin : g_multi_slice
    assign w_res_next = {w_sum, r_res[WIDTH-1:SLICE_W]};
  end

  assign w_b_eff = op_sub ? ~b : b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_op_sub    <= 1'b0;
      r_sign_a    <= 1'b0;
      r_sign_b    <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
      r_borrow    <= 1'b0;
      r_overflow  <= 1'b0;
      r_zero      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= a;
            r_b        <= w_b_eff;
            r_op_sub   <= op_sub;
            r_sign_a   <= a[WIDTH-1];
            r_sign_b   <= w_b_eff[WIDTH-1];
            r_carry    <= op_sub;  // the +1 of two's-complement negation
            r_cnt      <= '0;
            r_in_ready <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          r_a     <= r_a >> SLICE_W;
          r_b     <= r_b >> SLICE_W;
          r_res   <= w_res_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            // Visible outputs update only here so they hold between results.
            r_result    <= w_res_next;
            r_carry_out <= w_cout;
            r_borrow    <= r_op_sub & ~w_cout;
            r_overflow  <= (r_sign_a == r_sign_b) & (w_res_next[WIDTH-1] != r_sign_a);
            r_zero      <= ~|w_res_next;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign carry_out = r_carry_out;
  assign borrow    = r_borrow;
  assign overflow  = r_overflow;
  assign zero      = r_zero;

endmodule
